// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// seg_display_scan: snapshots CPU debug fields, selects a 16-bit page and
// scans it as 4 hex digits onto a common-anode 7-segment display.
// Revision: 1.0
// ============================================================================
module seg_display_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cap_en,
  input  logic [2:0]  sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  op_code,
  input  logic [31:0] ins_data,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_data,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        snap_valid
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [5:0]       op_q, op_d;
  logic [31:0]      ins_q, ins_d, alu_q, alu_d, mem_q, mem_d;
  logic             valid_q, valid_d;
  logic [15:0]      disp_word_q, disp_word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  logic [3:0]       nibble;
  logic [6:0]       hex7;
  logic             dp_n;

  always_comb begin
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    op_d    = op_q;
    ins_d   = ins_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    valid_d = valid_q;
    if (cap_en) begin
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
      op_d    = op_code;
      ins_d   = ins_data;
      alu_d   = alu_out;
      mem_d   = mem_data;
      valid_d = 1'b1;
    end
  end

  // Page is taken from the snapshot, so the display is one edge behind a capture.
  always_comb begin
    disp_word_d = 16'h0000;
    case (sel)
      3'd0:    disp_word_d = {3'b000, rs_q, 3'b000, rt_q};
      3'd1:    disp_word_d = {3'b000, rd_q, 2'b00, op_q};
      3'd2:    disp_word_d = alu_q[15:0];
      3'd3:    disp_word_d = alu_q[31:16];
      3'd4:    disp_word_d = mem_q[15:0];
      3'd5:    disp_word_d = mem_q[31:16];
      3'd6:    disp_word_d = ins_q[15:0];
      default: disp_word_d = ins_q[31:16];
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      op_q        <= '0;
      ins_q       <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      valid_q     <= 1'b0;
      disp_word_q <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
    end else begin
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      op_q        <= op_d;
      ins_q       <= ins_d;
      alu_q       <= alu_d;
      mem_q       <= mem_d;
      valid_q     <= valid_d;
      disp_word_q <= disp_word_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
    end
  end

  assign nibble = disp_word_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    hex7 = 7'h7F;
    case (nibble)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  end

  // dp marks the upper half-word on the leftmost digit, and "no capture yet" on the rightmost.
  always_comb begin
    dp_n = 1'b1;
    if ((idx_q == 2'd3) && sel[0] && (sel[2:1] != 2'b00)) dp_n = 1'b0;
    if ((idx_q == 2'd0) && !valid_q)                      dp_n = 1'b0;
  end

  // cnt==0 is a blank slot so the anode switch never shows the previous digit's segments.
  always_comb begin
    an  = 4'hF;
    seg = 8'hFF;
    if (cnt_q != '0) begin
      an  = ~(4'b0001 << idx_q);
      seg = {dp_n, hex7};
    end
  end

  assign snap_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
// tb_seg_display_scan: table vectors, hand sequences and random stimulus
// against a cycle-count reference model of the display scanner.
// Revision: 1.0
// ============================================================================
module tb_seg_display_scan;

  localparam int SD = 4;

  logic        CLK, RST, cap_en;
  logic [2:0]  sel;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  op_code;
  logic [31:0] ins_data, alu_out, mem_data;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        snap_valid;

  seg_display_scan #(.SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST(RST), .cap_en(cap_en), .sel(sel),
    .rs(rs), .rt(rt), .rd(rd), .op_code(op_code),
    .ins_data(ins_data), .alu_out(alu_out), .mem_data(mem_data),
    .an(an), .seg(seg), .snap_valid(snap_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: snapshot fields, displayed word, and edges since reset release.
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [5:0]  m_op;
  logic [31:0] m_ins, m_alu, m_mem;
  logic        m_valid;
  logic [15:0] m_disp;
  int          m_t;

  typedef struct {
    logic        cap;
    logic [2:0]  sel;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op;
    logic [31:0] ins, alu, mem;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] page_of(input logic [2:0] s);
    logic [31:0] w;
    case (s)
      3'd0: w = 32'(m_rs) * 256 + 32'(m_rt);
      3'd1: w = 32'(m_rd) * 256 + 32'(m_op);
      3'd2: w = m_alu % 65536;
      3'd3: w = m_alu / 65536;
      3'd4: w = m_mem % 65536;
      3'd5: w = m_mem / 65536;
      3'd6: w = m_ins % 65536;
      default: w = m_ins / 65536;
    endcase
    return w[15:0];
  endfunction

  function automatic logic [3:0] exp_an();
    int c, d;
    c = m_t % SD;
    d = (m_t / SD) % 4;
    if (c == 0) return 4'hF;
    return 4'(15 - (1 << d));
  endfunction

  function automatic logic [7:0] exp_seg();
    int c, d;
    logic [3:0] n;
    logic [7:0] p;
    logic dp;
    c = m_t % SD;
    d = (m_t / SD) % 4;
    if (c == 0) return 8'hFF;
    n = 4'((m_disp >> (4 * d)) % 16);
    p = HEX[n];
    dp = 1'b1;
    if (d == 3 && (sel % 2 == 1) && sel >= 2) dp = 1'b0;
    if (d == 0 && !m_valid) dp = 1'b0;
    return {dp, p[6:0]};
  endfunction

  task automatic model_reset();
    m_rs = '0; m_rt = '0; m_rd = '0; m_op = '0;
    m_ins = '0; m_alu = '0; m_mem = '0;
    m_valid = 1'b0; m_disp = '0; m_t = 0;
  endtask

  // One clock edge: advance the model with the inputs currently applied, then compare.
  task automatic tick();
    logic [15:0] nd;
    nd = page_of(sel);
    if (cap_en) begin
      m_rs = rs; m_rt = rt; m_rd = rd; m_op = op_code;
      m_ins = ins_data; m_alu = alu_out; m_mem = mem_data;
      m_valid = 1'b1;
    end
    m_disp = nd;
    m_t++;
    @(posedge CLK);
    @(negedge CLK);
    chk("an", 32'(an), 32'(exp_an()));
    chk("seg", 32'(seg), 32'(exp_seg()));
    chk("snap_valid", 32'(snap_valid), 32'(m_valid));
  endtask

  task automatic randomize_fields();
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    op_code = 6'($urandom);
    ins_data = $urandom; alu_out = $urandom; mem_data = $urandom;
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd2, 5'd0,  5'd0,  5'd0,  6'd0,  32'h0,        32'h1234ABCD, 32'h0,        16'hABCD};
    vecs[1] = '{1'b0, 3'd3, 5'd0,  5'd0,  5'd0,  6'd0,  32'h0,        32'h0,        32'h0,        16'h1234};
    vecs[2] = '{1'b0, 3'd2, 5'd0,  5'd0,  5'd0,  6'd0,  32'h0,        32'h0,        32'h0,        16'hABCD};
    vecs[3] = '{1'b1, 3'd4, 5'd0,  5'd0,  5'd0,  6'd0,  32'h0,        32'h0,        32'h0000BEEF, 16'hBEEF};
    vecs[4] = '{1'b1, 3'd0, 5'd17, 5'd31, 5'd0,  6'd0,  32'h0,        32'h0,        32'h0,        16'h111F};
    vecs[5] = '{1'b1, 3'd1, 5'd0,  5'd0,  5'h15, 6'h2A, 32'h0,        32'h0,        32'hDEAD0000, 16'h152A};
    vecs[6] = '{1'b0, 3'd5, 5'd0,  5'd0,  5'd0,  6'd0,  32'h0,        32'h0,        32'h0,        16'hDEAD};
    vecs[7] = '{1'b1, 3'd6, 5'd0,  5'd0,  5'd0,  6'd0,  32'h89AB7654, 32'h0,        32'h0,        16'h7654};
    vecs[8] = '{1'b0, 3'd7, 5'd0,  5'd0,  5'd0,  6'd0,  32'h0,        32'h0,        32'h0,        16'h89AB};

    RST = 1'b0; cap_en = 1'b0; sel = 3'd0;
    rs = '0; rt = '0; rd = '0; op_code = '0;
    ins_data = '0; alu_out = '0; mem_data = '0;
    model_reset();

    // Reset hold, then release and the first digit slots.
    @(negedge CLK); @(negedge CLK);
    chk("reset_an", 32'(an), 32'h0000000F);
    chk("reset_seg", 32'(seg), 32'h000000FF);
    chk("reset_valid", 32'(snap_valid), 32'h0);
    RST = 1'b1;
    tick();
    chk("edge1_an", 32'(an), 32'hE);
    chk("edge1_seg", 32'(seg), 32'h40);
    tick(); tick();
    chk("edge3_seg", 32'(seg), 32'h40);
    tick();
    chk("edge4_an", 32'(an), 32'hF);
    tick();
    chk("edge5_an", 32'(an), 32'hD);
    chk("edge5_seg", 32'(seg), 32'hC0);

    // Table vectors: capture (or just reselect), then scan a full refresh period.
    for (int v = 0; v < 9; v++) begin
      sel = vecs[v].sel;
      cap_en = vecs[v].cap;
      if (vecs[v].cap) begin
        rs = vecs[v].rs; rt = vecs[v].rt; rd = vecs[v].rd; op_code = vecs[v].op;
        ins_data = vecs[v].ins; alu_out = vecs[v].alu; mem_data = vecs[v].mem;
      end else begin
        randomize_fields();
      end
      tick();
      cap_en = 1'b0;
      randomize_fields();
      tick();
      for (int k = 0; k < 4 * SD; k++) begin
        logic [15:0] w;
        logic [7:0]  h;
        tick();
        w = vecs[v].exp_word;
        for (int d = 0; d < 4; d++) begin
          if (an == 4'(15 - (1 << d))) begin
            h = HEX[4'((w >> (4 * d)) % 16)];
            chk($sformatf("vec%0d_digit%0d", v, d), 32'(seg[6:0]), 32'(h[6:0]));
          end
        end
      end
    end

    // Asynchronous reset in the middle of digit 2's lit slot.
    for (int k = 0; k < 32 && (m_t % 16) != 10; k++) tick();
    chk("pre_reset_an", 32'(an), 32'hB);
    #1;
    RST = 1'b0;
    #1;
    chk("midreset_an", 32'(an), 32'hF);
    chk("midreset_seg", 32'(seg), 32'hFF);
    chk("midreset_valid", 32'(snap_valid), 32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    sel = 3'd2;
    tick();
    chk("post_reset_an", 32'(an), 32'hE);
    chk("post_reset_seg", 32'(seg), 32'h40);
    for (int k = 0; k < 4 * SD; k++) tick();

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      randomize_fields();
      cap_en = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) sel = 3'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
